// File: rtl/apb_master_arb.sv
//------------------------------------------------------------------------------
// apb_master_arb
//
// Two-requester APB master with round-robin arbitration. Requester 0 is the CPU
// load/store port, requester 1 a secondary master (debug/DMA). One transfer is
// in flight at a time. The granted address is decoded into one of four slave
// selects inside a 16 KiB window at BASE_ADDR. The block runs the APB
// SETUP/ACCESS sequence and returns read data plus a done pulse and an error
// flag to the granted requester.
//
// Parameters
//   BASE_ADDR  peripheral window base; slave n at BASE_ADDR + n*0x1000
//   TIMEOUT    ACCESS cycles without PREADY before abort (2..255)
//
// Ports
//   PCLK, PRESETn                clock, asynchronous active-low reset
//   m0_*/m1_*  req/addr/wdata/write  requester inputs (req held until done)
//   m0_done, m1_done             one-cycle completion pulse per requester
//   rd_data, rd_err              result, valid in the done cycle
//   PADDR, PWDATA, PWRITE,
//   PENABLE, PSEL[3:0]           APB master outputs (all registered)
//   PRDATA0..3, PREADY[3:0]      per-slave read data and ready
//------------------------------------------------------------------------------
module apb_master_arb #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_write,
    output logic        m0_done,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_write,
    output logic        m1_done,

    output logic [31:0] rd_data,
    output logic        rd_err,

    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic [3:0]  PSEL,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic [3:0]  PREADY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } state_t;

    localparam logic [17:0] BASE_HI = BASE_ADDR[31:14];
    // Counter value seen in the TIMEOUT-th ACCESS cycle (counter starts at 0)
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

    // ---------------------------------------------------------------- state
    state_t      r_state;
    logic        r_grant;       // 0 = m0, 1 = m1 owns the current transfer
    logic        r_last_grant;  // requester granted most recently
    logic [1:0]  r_idx;         // decoded slave index of current transfer
    logic [7:0]  r_cnt;         // ACCESS cycles elapsed without PREADY
    logic        r_done_pend;   // hit path: done pulse still owed in DONE

    logic        r_m0_done;
    logic        r_m1_done;
    logic [31:0] r_rd_data;
    logic        r_rd_err;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;
    logic        r_penable;
    logic [3:0]  r_psel;

    // ---------------------------------------------------------------- comb
    logic        w_gnt_valid;
    logic        w_gnt;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_write;
    logic        w_hit;
    logic [1:0]  w_idx;
    logic [31:0] w_prdata;
    logic        w_pready;

    // Round-robin: on a tie the requester that did not win last time wins.
    always_comb begin
        w_gnt_valid = m0_req | m1_req;
        if (m0_req && m1_req) begin
            w_gnt = ~r_last_grant;
        end else begin
            w_gnt = m1_req;
        end
    end

    always_comb begin
        if (w_gnt) begin
            w_addr  = m1_addr;
            w_wdata = m1_wdata;
            w_write = m1_write;
        end else begin
            w_addr  = m0_addr;
            w_wdata = m0_wdata;
            w_write = m0_write;
        end
        w_hit = (w_addr[31:14] == BASE_HI);
        w_idx = w_addr[13:12];
    end

    // Only the selected slave's ready and data are ever looked at.
    always_comb begin
        w_prdata = '0;
        case (r_idx)
            2'd0:    w_prdata = PRDATA0;
            2'd1:    w_prdata = PRDATA1;
            2'd2:    w_prdata = PRDATA2;
            default: w_prdata = PRDATA3;
        endcase
        w_pready = PREADY[r_idx];
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_done_pend  <= 1'b0;
            r_m0_done    <= 1'b0;
            r_m1_done    <= 1'b0;
            r_rd_data    <= '0;
            r_rd_err     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_pwrite     <= 1'b0;
            r_penable    <= 1'b0;
            r_psel       <= '0;
        end else begin
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant      <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_cnt        <= '0;
                        if (w_hit) begin
                            r_idx       <= w_idx;
                            r_paddr     <= w_addr;
                            r_pwdata    <= w_wdata;
                            r_pwrite    <= w_write;
                            r_psel      <= 4'b0001 << w_idx;
                            r_penable   <= 1'b0;
                            r_done_pend <= 1'b0;
                            r_state     <= ST_SETUP;
                        end else begin
                            // Decode miss: the bus stays quiet and the done
                            // pulse goes out together with the move to DONE,
                            // so DONE itself has nothing left to signal.
                            r_rd_data   <= '0;
                            r_rd_err    <= 1'b1;
                            r_m0_done   <= ~w_gnt;
                            r_m1_done   <= w_gnt;
                            r_done_pend <= 1'b0;
                            r_state     <= ST_DONE;
                        end
                    end
                end

                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (w_pready) begin
                        r_rd_data   <= r_pwrite ? '0 : w_prdata;
                        r_rd_err    <= 1'b0;
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_done_pend <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_rd_data   <= '0;
                        r_rd_err    <= 1'b1;
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_done_pend <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_DONE: begin
                    r_m0_done   <= r_done_pend & ~r_grant;
                    r_m1_done   <= r_done_pend & r_grant;
                    r_done_pend <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign m0_done = r_m0_done;
    assign m1_done = r_m1_done;
    assign rd_data = r_rd_data;
    assign rd_err  = r_rd_err;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign PWRITE  = r_pwrite;
    assign PENABLE = r_penable;
    assign PSEL    = r_psel;

endmodule

// File: tb/tb_apb_master_arb.sv
//------------------------------------------------------------------------------
// tb_apb_master_arb
//
// Transaction-level reference: each granted transfer is turned into a schedule
// (SETUP cycle, number of ACCESS cycles, done cycle, result) from which the
// expected PSEL/PENABLE/done/result are derived every cycle. Requesters are
// queues of transfers; the slave side is driven from the same schedule.
//------------------------------------------------------------------------------
module tb_apb_master_arb;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          TMO  = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_write, m1_write;
    logic        m0_done, m1_done;
    logic [31:0] rd_data;
    logic        rd_err;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic [3:0]  PREADY;

    apb_master_arb #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_write(m0_write), .m0_done(m0_done),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_write(m1_write), .m1_done(m1_done),
        .rd_data(rd_data), .rd_err(rd_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PSEL(PSEL),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
        .PRDATA3(PRDATA3), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // k = ACCESS cycle in which the slave raises PREADY (k > TMO: never)
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        int          k;
        logic [31:0] rdata;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    int   gap0, gap1;
    bit   rand_gaps;

    // Reference schedule of the transfer in flight
    bit          busy;
    int          cyc, t0, acc, done_c, free_c, who, lastg;
    bit          hit;
    logic [1:0]  sidx;
    txn_t        cur;
    logic        m_err;
    logic [31:0] m_data;
    bit          pend_release;

    // Observation logs used by the hand-computed checks
    int          grant_cyc[$];
    int          dd_who[$];
    int          dd_cyc[$];
    logic [31:0] dd_data[$];
    logic        dd_err[$];
    int          psel_cycles, pen_cycles;
    logic [31:0] last_pwdata;

    int vectors, miscompares;

    function automatic txn_t mk(input logic [31:0] a, input logic [31:0] wd,
                                input logic w, input int k, input logic [31:0] rd);
        txn_t t;
        t.addr = a; t.wdata = wd; t.write = w; t.k = k; t.rdata = rd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        grant_cyc.delete(); dd_who.delete(); dd_cyc.delete();
        dd_data.delete(); dd_err.delete();
        psel_cycles = 0; pen_cycles = 0; last_pwdata = '0;
    endtask

    task automatic set_prdata(input logic [1:0] s, input logic [31:0] v);
        case (s)
            2'd0:    PRDATA0 = v;
            2'd1:    PRDATA1 = v;
            2'd2:    PRDATA2 = v;
            default: PRDATA3 = v;
        endcase
    endtask

    task automatic drive_req();
        if (gap0 > 0) gap0--;
        if (gap1 > 0) gap1--;
        m0_req = (q0.size() > 0 && gap0 == 0);
        m1_req = (q1.size() > 0 && gap1 == 0);
        if (m0_req) begin
            m0_addr = q0[0].addr; m0_wdata = q0[0].wdata; m0_write = q0[0].write;
        end else begin
            m0_addr = $urandom; m0_wdata = $urandom; m0_write = 1'($urandom);
        end
        if (m1_req) begin
            m1_addr = q1[0].addr; m1_wdata = q1[0].wdata; m1_write = q1[0].write;
        end else begin
            m1_addr = $urandom; m1_wdata = $urandom; m1_write = 1'($urandom);
        end
    endtask

    task automatic drive_slave();
        int j;
        PREADY  = 4'($urandom);
        PRDATA0 = $urandom; PRDATA1 = $urandom; PRDATA2 = $urandom; PRDATA3 = $urandom;
        if (busy && hit) begin
            j = cyc - (t0 + 1);   // 0 = SETUP, 1.. = ACCESS cycles
            if (j >= 1) PREADY[sidx] = (j >= cur.k);
            if (j == cur.k) set_prdata(sidx, cur.rdata);
        end
    endtask

    task automatic arbitrate();
        int w;
        if (m0_req || m1_req) begin
            if (m0_req && m1_req) w = (lastg == 1) ? 0 : 1;
            else                  w = m1_req ? 1 : 0;
            cur   = (w == 0) ? q0[0] : q1[0];
            who   = w;
            lastg = w;
            t0    = cyc;
            busy  = 1;
            hit   = ((cur.addr >> 14) == (BASE >> 14));
            sidx  = cur.addr[13:12];
            if (hit) begin
                if (cur.k <= TMO) begin
                    acc = cur.k; m_err = 1'b0;
                    m_data = cur.write ? 32'h0 : cur.rdata;
                end else begin
                    acc = TMO; m_err = 1'b1; m_data = 32'h0;
                end
                done_c = t0 + 3 + acc;
                free_c = done_c;
            end else begin
                m_err = 1'b1; m_data = 32'h0;
                done_c = t0 + 1;
                free_c = t0 + 2;
            end
            grant_cyc.push_back(cyc);
        end
    endtask

    // One clock cycle: check outputs, react as requesters, drive inputs.
    task automatic step();
        logic [3:0] e_psel;
        logic       e_pen, e_d0, e_d1;
        @(posedge PCLK);
        #1;
        if (pend_release) begin
            PRESETn = 1'b1;
            pend_release = 0;
        end
        cyc++;
        e_psel = '0; e_pen = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
        if (busy) begin
            if (hit && cyc >= t0 + 1 && cyc <= t0 + 1 + acc) e_psel = 4'b0001 << sidx;
            if (hit && cyc >= t0 + 2 && cyc <= t0 + 1 + acc) e_pen = 1'b1;
            if (cyc == done_c) begin
                e_d0 = (who == 0);
                e_d1 = (who == 1);
            end
        end
        chk("PSEL", 32'(PSEL), 32'(e_psel));
        chk("PENABLE", 32'(PENABLE), 32'(e_pen));
        chk("m0_done", 32'(m0_done), 32'(e_d0));
        chk("m1_done", 32'(m1_done), 32'(e_d1));
        if (e_psel != 4'b0000) begin
            chk("PADDR", PADDR, cur.addr);
            chk("PWDATA", PWDATA, cur.wdata);
            chk("PWRITE", 32'(PWRITE), 32'(cur.write));
        end
        if (e_d0 || e_d1) begin
            chk("rd_data", rd_data, m_data);
            chk("rd_err", 32'(rd_err), 32'(m_err));
        end

        if (PSEL != 4'b0000) begin
            psel_cycles++;
            last_pwdata = PWDATA;
        end
        if (PENABLE === 1'b1) pen_cycles++;
        if (m0_done === 1'b1) begin
            dd_who.push_back(0); dd_cyc.push_back(cyc);
            dd_data.push_back(rd_data); dd_err.push_back(rd_err);
        end
        if (m1_done === 1'b1) begin
            dd_who.push_back(1); dd_cyc.push_back(cyc);
            dd_data.push_back(rd_data); dd_err.push_back(rd_err);
        end

        if (busy && cyc == done_c) begin
            if (who == 0) begin
                q0.delete(0);
                gap0 = rand_gaps ? int'($urandom_range(0, 3)) : 0;
            end else begin
                q1.delete(0);
                gap1 = rand_gaps ? int'($urandom_range(0, 3)) : 0;
            end
        end
        if (busy && cyc == free_c) busy = 0;

        drive_req();
        drive_slave();
        if (!busy) arbitrate();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (q0.size() > 0 || q1.size() > 0 || busy) begin
            miscompares++;
            $display("FAIL drain: transfers still pending after %0d cycles (q0=%0d q1=%0d), expected none",
                     budget, q0.size(), q1.size());
        end
        step();
    endtask

    task automatic check_one(input string name, input int exp_who, input int exp_lat,
                             input logic [31:0] exp_data, input logic exp_err);
        chk({name, "_done_count"}, 32'(dd_who.size()), 32'd1);
        if (dd_who.size() >= 1 && grant_cyc.size() >= 1) begin
            chk({name, "_who"}, 32'(dd_who[0]), 32'(exp_who));
            chk({name, "_latency"}, 32'(dd_cyc[0] - grant_cyc[0]), 32'(exp_lat));
            chk({name, "_rd_data"}, dd_data[0], exp_data);
            chk({name, "_rd_err"}, 32'(dd_err[0]), 32'(exp_err));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_PSEL"}, 32'(PSEL), 32'h0);
        chk({name, "_PENABLE"}, 32'(PENABLE), 32'h0);
        chk({name, "_PWRITE"}, 32'(PWRITE), 32'h0);
        chk({name, "_PADDR"}, PADDR, 32'h0);
        chk({name, "_PWDATA"}, PWDATA, 32'h0);
        chk({name, "_m0_done"}, 32'(m0_done), 32'h0);
        chk({name, "_m1_done"}, 32'(m1_done), 32'h0);
        chk({name, "_rd_data"}, rd_data, 32'h0);
        chk({name, "_rd_err"}, 32'(rd_err), 32'h0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order [6];
        int n;
        txn_t t;

        vectors = 0; miscompares = 0;
        PRESETn = 1'b0; pend_release = 0;
        m0_req = 1'b0; m1_req = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        m0_write = 1'b0; m1_write = 1'b0;
        PRDATA0 = '0; PRDATA1 = '0; PRDATA2 = '0; PRDATA3 = '0; PREADY = '0;
        gap0 = 0; gap1 = 0; rand_gaps = 0;
        busy = 0; cyc = 0; lastg = 1; who = 0; t0 = 0; acc = 0;
        done_c = 0; free_c = 0; hit = 0; sidx = '0; m_err = 1'b0; m_data = '0;
        cur = mk('0, '0, 1'b0, 1, '0);
        clear_logs();

        repeat (3) @(posedge PCLK);
        #1;
        check_reset_outputs("reset");
        pend_release = 1;
        step(); step();

        // m0 write to slave 0, zero-wait
        clear_logs();
        q0.push_back(mk(32'h1000_0000, 32'h0000_00A5, 1'b1, 1, 32'hDEAD_BEEF));
        run_until_idle(50);
        check_one("t1", 0, 4, 32'h0, 1'b0);
        chk("t1_psel_cycles", 32'(psel_cycles), 32'd2);
        chk("t1_penable_cycles", 32'(pen_cycles), 32'd1);
        chk("t1_pwdata", last_pwdata, 32'h0000_00A5);

        // m1 read from slave 1, one wait cycle
        clear_logs();
        q1.push_back(mk(32'h1000_1004, 32'h5555_0000, 1'b0, 2, 32'h0000_003C));
        run_until_idle(50);
        check_one("t2", 1, 5, 32'h0000_003C, 1'b0);

        // decode miss
        clear_logs();
        q0.push_back(mk(32'h2000_0000, 32'h0, 1'b0, 1, 32'h1111_1111));
        run_until_idle(50);
        check_one("t3", 0, 1, 32'h0, 1'b1);
        chk("t3_psel_cycles", 32'(psel_cycles), 32'd0);

        // slave 2 never ready: abort after TMO ACCESS cycles
        clear_logs();
        q0.push_back(mk(32'h1000_2000, 32'h0, 1'b0, 99, 32'h2222_2222));
        run_until_idle(80);
        check_one("t4", 0, 3 + TMO, 32'h0, 1'b1);
        chk("t4_psel_cycles", 32'(psel_cycles), 32'(1 + TMO));

        // following transfer is unaffected
        clear_logs();
        q1.push_back(mk(32'h1000_3008, 32'h0, 1'b0, 1, 32'h1234_5678));
        run_until_idle(50);
        check_one("t5", 1, 4, 32'h1234_5678, 1'b0);

        // both requesting continuously, registered-ready slaves
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(32'h1000_0000 + 32'(4 * i), 32'(i), 1'b1, 2, 32'h0));
            q1.push_back(mk(32'h1000_1000 + 32'(4 * i), 32'h0, 1'b0, 2, 32'hC0DE_0000 + 32'(i)));
        end
        run_until_idle(100);
        exp_order = '{0, 1, 0, 1, 0, 1};
        chk("tie_done_count", 32'(dd_who.size()), 32'd6);
        if (dd_who.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("tie_order", 32'(dd_who[i]), 32'(exp_order[i]));
            for (int i = 0; i < 5; i++) chk("tie_spacing", 32'(dd_cyc[i + 1] - dd_cyc[i]), 32'd5);
        end

        // reset in the middle of ACCESS, then a tie
        clear_logs();
        q0.push_back(mk(32'h1000_1010, 32'hAAAA_0001, 1'b1, 99, 32'h0));
        q1.push_back(mk(32'h1000_2020, 32'h0, 1'b0, 99, 32'h3333_3333));
        n = 0;
        while (!(busy && hit && cyc == t0 + 3) && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (!(busy && hit && cyc == t0 + 3)) begin
            miscompares++;
            $display("FAIL reach_access: ACCESS not reached within 50 cycles, expected reached");
        end
        #2;
        PRESETn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        busy = 0;
        lastg = 1;
        @(posedge PCLK);
        #1;
        chk("midrst_hold_m0_done", 32'(m0_done), 32'h0);
        chk("midrst_hold_m1_done", 32'(m1_done), 32'h0);
        t = q0[0]; t.k = 2; q0[0] = t;
        t = q1[0]; t.k = 2; t.rdata = 32'h4444_4444; q1[0] = t;
        clear_logs();
        pend_release = 1;
        run_until_idle(60);
        chk("postrst_done_count", 32'(dd_who.size()), 32'd2);
        if (dd_who.size() >= 1) chk("postrst_first_winner", 32'(dd_who[0]), 32'd0);

        // randomized traffic
        rand_gaps = 1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            int kk, r;
            if ($urandom_range(0, 99) < 85)
                a = BASE + 32'($urandom_range(0, 3) << 12) + ($urandom & 32'h0000_0FFC);
            else
                a = $urandom;
            r = int'($urandom_range(0, 9));
            if (r < 7)       kk = 1 + int'($urandom_range(0, 3));
            else if (r == 7) kk = TMO;
            else if (r == 8) kk = TMO + 1;
            else             kk = 40;
            if ($urandom_range(0, 1) == 0)
                q0.push_back(mk(a, $urandom, 1'($urandom), kk, $urandom));
            else
                q1.push_back(mk(a, $urandom, 1'($urandom), kk, $urandom));
        end
        run_until_idle(20000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
